frame_scan_plotter: RTL and testbench

- Parametrised successor to the game's per-frame pixel renderer.
- On each frame tick: snapshots the packed game-state vector, raster-scans every (x,y) of a configurable screen, waits a configurable colour-lookup latency, then presents each pixel to the VGA plot interface with ready/valid back-pressure.
- Sits between the game-logic/colour-renderer blocks and the VGA adapter.
- Adds over the previous renderer: arbitrary lookup latency, back-pressure, busy/done/overrun status, and an optional scan window.

---
 rtl/frame_scan_plotter_if.sv | 15 +
 rtl/frame_scan_plotter.sv | 161 ++++++++++++++++
 tb/tb_frame_scan_plotter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_scan_plotter_if.sv
// frame_scan_plotter_if: VGA plot bus between the scan plotter and the VGA adapter
// Signals: x/y scan coordinate, color pixel colour, plot pixel valid (master),
//          plot_ready pixel accepted (slave).
interface frame_scan_plotter_if #(
    parameter int COORD_W = 8,
    parameter int COLOR_W = 3
);
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
    logic               plot;
    logic               plot_ready;
    modport master (output x, y, color, plot, input plot_ready);
    modport slave  (input x, y, color, plot, output plot_ready);
endinterface

// File: rtl/frame_scan_plotter.sv
// frame_scan_plotter: per-frame raster scanner feeding the VGA plot bus with ready/valid back-pressure
// Ports: clk, reset (sync, high), enable (freeze when low), frame_start (tick),
//        snap_in/snap_out (game-state snapshot), color_in (renderer colour for x/y),
//        busy, frame_done, overrun (status), vga (plot bus master: x, y, color, plot, plot_ready).
// Optional macro FRAME_SCAN_WINDOW_EN adds win_x0/win_y0/win_x1/win_y1 scan window inputs.
module frame_scan_plotter #(
    parameter int                 COORD_W    = 8,
    parameter int                 X_MAX      = 159,
    parameter int                 Y_MAX      = 119,
    parameter int                 COLOR_W    = 3,
    parameter int                 SNAP_W     = 40,
    parameter logic [SNAP_W-1:0]  SNAP_RESET = '0,
    parameter int                 COLOR_LAT  = 1,
    parameter logic [COLOR_W-1:0] BG_COLOR   = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               frame_start,
    input  logic [SNAP_W-1:0]  snap_in,
    output logic [SNAP_W-1:0]  snap_out,
    input  logic [COLOR_W-1:0] color_in,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun,
`ifdef FRAME_SCAN_WINDOW_EN
    input  logic [COORD_W-1:0] win_x0,
    input  logic [COORD_W-1:0] win_y0,
    input  logic [COORD_W-1:0] win_x1,
    input  logic [COORD_W-1:0] win_y1,
`endif
    frame_scan_plotter_if.master vga
);
    typedef enum logic [1:0] {IDLE, SETTLE, PLOT} state_t;
    localparam logic [3:0]         LAT1 = 4'(COLOR_LAT - 1);
    localparam logic [COORD_W-1:0] XM   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YM   = COORD_W'(Y_MAX);
    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               plot_q, plot_d, busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
    logic [SNAP_W-1:0]  snap_q, snap_d;
    // xo/yo: first pixel of a new frame; xs: column a row wraps to; xe/ye: last pixel
    logic [COORD_W-1:0] xo, yo, xs, xe, ye;
    // nil: the accepted frame covers no pixels and finishes straight from SETTLE
    logic               nil;
    wire                start = enable && frame_start && state_q == IDLE;
`ifdef FRAME_SCAN_WINDOW_EN
    logic [COORD_W-1:0] wx0_q, wx1_q, wy1_q;
    logic               empty_q;
    wire                bad = win_x1 < win_x0 || win_y1 < win_y0 || win_x1 > XM || win_y1 > YM;
    always_ff @(posedge clk) begin
        if (reset) begin
            wx0_q   <= '0;
            wx1_q   <= XM;
            wy1_q   <= YM;
            empty_q <= 1'b0;
        end else if (start) begin
            wx0_q   <= win_x0;
            wx1_q   <= win_x1;
            wy1_q   <= win_y1;
            empty_q <= bad;
        end
    end
    assign xo  = win_x0;
    assign yo  = win_y0;
    assign xs  = wx0_q;
    assign xe  = wx1_q;
    assign ye  = wy1_q;
    assign nil = empty_q;
`else
    assign xo  = '0;
    assign yo  = '0;
    assign xs  = '0;
    assign xe  = XM;
    assign ye  = YM;
    assign nil = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        plot_d  = plot_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        snap_d  = snap_q;
        if (enable) begin
            done_d = 1'b0;
            ovr_d  = frame_start && state_q != IDLE;
            if (start) begin
                snap_d  = snap_in;
                x_d     = xo;
                y_d     = yo;
                cnt_d   = LAT1;
                busy_d  = 1'b1;
                state_d = SETTLE;
            end else if (state_q == SETTLE) begin
                if (nil) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    color_d = color_in;
                    plot_d  = 1'b1;
                    state_d = PLOT;
                end
            end else if (state_q == PLOT && vga.plot_ready) begin
                plot_d = 1'b0;
                if (x_q == xe && y_q == ye) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    x_d     = x_q == xe ? xs : x_q + 1'b1;
                    y_d     = x_q == xe ? y_q + 1'b1 : y_q;
                    cnt_d   = LAT1;
                    state_d = SETTLE;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= BG_COLOR;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            snap_q  <= SNAP_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            snap_q  <= snap_d;
        end
    end
    assign vga.x      = x_q;
    assign vga.y      = y_q;
    assign vga.color  = color_q;
    assign vga.plot   = plot_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = ovr_q;
    assign snap_out   = snap_q;
endmodule

// File: tb/tb_frame_scan_plotter.sv
// tb_frame_scan_plotter: scoreboard bench for frame_scan_plotter on a 4x2 screen with 3-cycle colour latency
module tb_frame_scan_plotter;
    localparam int XM = 3, YM = 1, LAT = 3, CW = 3, SW = 40;
    typedef struct { logic [7:0] x; logic [7:0] y; logic [CW-1:0] c; } pix_t;
    logic          clk = 0, reset = 1, enable = 0, frame_start = 0;
    logic [SW-1:0] snap_in = '0, snap_out;
    logic [CW-1:0] color_in;
    logic          busy, frame_done, overrun;
    logic [7:0]    win_x0 = 0, win_y0 = 0, win_x1 = XM, win_y1 = YM;
    frame_scan_plotter_if #(.COORD_W(8), .COLOR_W(CW)) vga();
    frame_scan_plotter #(
        .COORD_W(8), .X_MAX(XM), .Y_MAX(YM), .COLOR_W(CW), .SNAP_W(SW),
        .SNAP_RESET('0), .COLOR_LAT(LAT), .BG_COLOR(3'b000)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
        .snap_in(snap_in), .snap_out(snap_out), .color_in(color_in),
        .busy(busy), .frame_done(frame_done), .overrun(overrun),
`ifdef FRAME_SCAN_WINDOW_EN
        .win_x0(win_x0), .win_y0(win_y0), .win_x1(win_x1), .win_y1(win_y1),
`endif
        .vga(vga)
    );
    always #5 clk = ~clk;
    int   n_vec = 0, n_err = 0, exp_done = 0, exp_ovr = 0, done_cnt = 0, ovr_cnt = 0;
    pix_t q[$];
    function automatic logic [CW-1:0] f(input logic [7:0] x, input logic [7:0] y, input logic [SW-1:0] s);
        return {x[1:0], y[0]} ^ s[2:0];
    endfunction
    // renderer stand-in: colour for the current x/y appears LAT cycles after x/y change
    logic [CW-1:0] r1 = '0, r2 = '0;
    always @(posedge clk) begin
        r1 <= f(vga.x, vga.y, snap_out);
        r2 <= r1;
    end
    assign color_in = r2;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic push_frame(input logic [SW-1:0] s);
        if (win_x1 < win_x0 || win_y1 < win_y0 || win_x1 > XM || win_y1 > YM) return;
        for (int yy = win_y0; yy <= win_y1; yy++)
            for (int xx = win_x0; xx <= win_x1; xx++)
                q.push_back('{x: 8'(xx), y: 8'(yy), c: f(8'(xx), 8'(yy), s)});
    endtask
    task automatic start_frame(input logic [SW-1:0] s);
        snap_in = s;
        frame_start = 1;
        @(posedge clk); #1;
        frame_start = 0;
        push_frame(s);
        exp_done++;
        chk("snap_load", snap_out, s);
        chk("busy_set", busy, 1);
    endtask
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!frame_done && cyc < 3000);
        if (!frame_done) chk("done_timeout", frame_done, 1);
    endtask
    task automatic chk_reset(input string name);
        chk(name, {vga.x, vga.y, vga.color, vga.plot, busy, frame_done, overrun}, 0);
        chk({name, "_snap"}, snap_out, 0);
    endtask
    // monitor: p_* hold what the next active edge sees/saw
    logic p_rst = 1, p_en = 0, p_plot = 0, p_rdy = 0, p_busy = 0, p_done = 0, p_ovr = 0;
    logic [7:0] p_x = 0, p_y = 0;
    logic [CW-1:0] p_c = 0;
    logic [SW-1:0] p_snap = 0;
    always @(negedge clk) begin
        if (!p_rst) begin
            if (!p_en) begin
                chk("freeze", {vga.plot, vga.x, vga.y, vga.color, busy, frame_done, overrun},
                    {p_plot, p_x, p_y, p_c, p_busy, p_done, p_ovr});
                chk("freeze_snap", snap_out, p_snap);
            end else begin
                if (p_plot && p_rdy) begin
                    chk("pix_expected", 64'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        pix_t e;
                        e = q.pop_front();
                        chk("pixel", {p_x, p_y, p_c}, {e.x, e.y, e.c});
                    end
                end
                if (p_plot && !p_rdy)
                    chk("stall_hold", {vga.plot, vga.x, vga.y, vga.color}, {1'b1, p_x, p_y, p_c});
                if (frame_done) begin
                    done_cnt++;
                    chk("done_drained", 64'(q.size()), 0);
                end
                if (overrun) ovr_cnt++;
            end
        end
        p_rst = reset; p_en = enable; p_plot = vga.plot; p_rdy = vga.plot_ready;
        p_x = vga.x; p_y = vga.y; p_c = vga.color; p_busy = busy; p_done = frame_done;
        p_ovr = overrun; p_snap = snap_out;
    end
    logic stop = 0;
    initial begin
        int cyc;
        logic [63:0] r;
        vga.plot_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset_state");
        reset = 0;
        enable = 1;
        repeat (2) @(posedge clk);
        #1;
        start_frame(40'h0);
        wait_done(cyc);
        chk("frame_cycles", cyc, 8 * (LAT + 1));
        @(posedge clk); #1;
        chk("done_pulse_clear", {frame_done, busy}, 0);
        start_frame(40'h3);
        fork
            begin
                int k = 0;
                do begin @(negedge clk); k++; end
                while (!(vga.plot && vga.x == 2 && vga.y == 0) && k < 200);
                chk("stall_target_seen", {vga.plot, vga.x, vga.y}, {1'b1, 8'd2, 8'd0});
                vga.plot_ready = 0;
                repeat (5) @(negedge clk);
                vga.plot_ready = 1;
            end
            wait_done(cyc);
        join
        chk("stall_cycles", cyc, 8 * (LAT + 1) + 5);
        start_frame(40'h12_3456_7891);
        repeat (10) @(posedge clk);
        #1;
        snap_in = 40'hA5;
        frame_start = 1;
        @(posedge clk); #1;
        frame_start = 0;
        exp_ovr++;
        chk("overrun_pulse", overrun, 1);
        chk("snap_kept", snap_out, 40'h12_3456_7891);
        @(posedge clk); #1;
        chk("overrun_clear", overrun, 0);
        wait_done(cyc);
        chk("snap_kept_end", snap_out, 40'h12_3456_7891);
        start_frame(40'hA5);
        wait_done(cyc);
        start_frame(40'h6);
        repeat (8 * (LAT + 1) - 1) @(posedge clk);
        #1;
        snap_in = 40'h77;
        frame_start = 1;
        @(posedge clk); #1;
        frame_start = 0;
        exp_ovr++;
        chk("last_edge_status", {frame_done, overrun, busy}, 3'b110);
        chk("last_edge_snap", snap_out, 40'h6);
        repeat (3) @(posedge clk);
        #1;
        start_frame(40'h5);
        repeat (9) @(posedge clk);
        #1;
        enable = 0;
        repeat (10) @(posedge clk);
        #1;
        enable = 1;
        wait_done(cyc);
        chk("enable_cycles", 19 + cyc, 8 * (LAT + 1) + 10);
        start_frame(40'h2);
        repeat (13) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        chk_reset("midscan_reset");
        q.delete();
        exp_done--;
        reset = 0;
        repeat (40) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            r = {$urandom, $urandom};
            start_frame(r[SW-1:0]);
            stop = 0;
            fork
                begin wait_done(cyc); stop = 1; end
                while (!stop) begin
                    @(negedge clk);
                    if (!stop) begin
                        vga.plot_ready = $urandom_range(0, 3) != 0;
                        enable = $urandom_range(0, 7) != 0;
                    end
                end
            join
            enable = 1;
            vga.plot_ready = 1;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
`ifdef FRAME_SCAN_WINDOW_EN
        win_x0 = 1; win_y0 = 0; win_x1 = 2; win_y1 = 1;
        start_frame(40'h4);
        wait_done(cyc);
        chk("window_cycles", cyc, 4 * (LAT + 1));
        repeat (2) @(posedge clk);
        #1;
        win_x0 = 2; win_x1 = 0;
        start_frame(40'h9);
        wait_done(cyc);
        chk("empty_window_cycles", cyc, 1);
        repeat (2) @(posedge clk);
        #1;
`endif
        repeat (5) @(posedge clk);
        #1;
        chk("done_count", done_cnt, exp_done);
        chk("overrun_count", ovr_cnt, exp_ovr);
        chk("queue_empty", 64'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
